vga_mem_responder: RTL and testbench
====================================

VGA_MEM_RESPONDER -- requirements
Module: vga_mem_responder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port cpu_we, input, 1, CPU word write enable.
REQ-004 SHALL have port cpu_addr, input, 32, CPU byte address; bits [9:2] select the word, other bits ignored.
REQ-005 SHALL have port cpu_wdata, input, 32, CPU write data.
REQ-006 SHALL have port cpu_rdata, output, 32, CPU combinational read data.
REQ-007 SHALL have port vga_req_valid, input, 1, VGA read request present.
REQ-008 SHALL have port vga_req_ready, output, 1, responder can accept a request.
REQ-009 SHALL have port vga_addr, input, 8, VGA word address, 0..255.
REQ-010 SHALL have port vga_rsp_valid, output, 1, vga_rdata holds a valid response.
REQ-011 SHALL have port vga_rsp_ready, input, 1, VGA consumes the response.
REQ-012 SHALL have port vga_rdata, output, 32, response data.
REQ-013 SHALL have port served_count, output, 16, number of responses consumed.

Function
REQ-014 SHALL hold 256 x 32-bit words, one CPU read/write port and one VGA read port.
REQ-015 SHALL drive cpu_rdata = mem[cpu_addr[9:2]] combinationally, with zero-cycle latency.
REQ-016 SHALL write cpu_wdata into mem[cpu_addr[9:2]] on the rising edge when cpu_we=1; the CPU is never stalled.
REQ-017 SHALL accept a request on the edge where vga_req_valid=1 and vga_req_ready=1.
REQ-018 SHALL read mem[vga_addr] on the accept edge and push it into a 2-entry response FIFO.
REQ-019 SHALL assert vga_rsp_valid in the cycle after acceptance, giving 1-cycle latency.
REQ-020 SHALL present the FIFO head on vga_rdata and hold it stable while vga_rsp_valid=1 and vga_rsp_ready=0.
REQ-021 SHALL pop the FIFO head on the edge where vga_rsp_valid=1 and vga_rsp_ready=1.
REQ-022 SHALL drive vga_req_ready = (count<2) OR (count==2 AND vga_rsp_ready=1).
REQ-023 SHALL leave count unchanged on a simultaneous push and pop.
REQ-024 SHALL never overflow the FIFO, nor pop when it is empty.
REQ-025 SHALL return responses in strict request order.
REQ-026 SHALL increment served_count on each pop, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL follow REQ-039/REQ-040 when a CPU write and a VGA accept target the same word on the same edge.

Reset
REQ-028 SHALL, on reset assertion, immediately clear FIFO count, vga_rsp_valid, vga_rdata and served_count to 0, independent of clk.
REQ-029 SHALL hold vga_req_ready=1 while reset is deasserted and the FIFO is empty.
REQ-030 SHALL discard in-flight and queued responses on a mid-operation reset; none are emitted after reset.
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL ignore cpu_we while reset is asserted.

Configuration
REQ-033 SHALL use the macro VGA_MEM_BYPASS_EN.
REQ-034 SHALL, when VGA_MEM_BYPASS_EN is defined, return cpu_wdata for a same-edge same-word CPU write and VGA accept (write-first).
REQ-035 SHALL, when VGA_MEM_BYPASS_EN is undefined, return the pre-write word in that case (read-first).
REQ-036 SHALL leave all other behaviour identical in both builds.

Verification
REQ-037 SHALL cover: after reset, CPU writes 0xDEADBEEF to byte address 0x14; VGA requests addr 5 with rsp_ready=1 -> vga_rsp_valid=1 exactly 1 cycle later with vga_rdata=0xDEADBEEF, and served_count=1.
REQ-038 SHALL cover: with vga_rsp_ready=0, three back-to-back requests to addrs 1,2,3 -> the first two are accepted and vga_req_ready=0 on the third; rsp_ready=1 then returns data for 1,2,3 in order.
REQ-039 SHALL cover: with VGA_MEM_BYPASS_EN, word 7 = 0x1, and a same-edge CPU write of 0x2 to word 7 with a VGA accept of addr 7 -> vga_rdata=0x2.
REQ-040 SHALL cover: the REQ-039 stimulus with VGA_MEM_BYPASS_EN undefined -> vga_rdata=0x1, and a later read of word 7 returns 0x2.
REQ-041 SHALL cover: with the FIFO full and vga_rsp_ready=1 plus a new request -> accepted on the same edge, count stays 2, and served_count increments by 1.
REQ-042 SHALL cover: served_count preloaded to 0xFFFF by 65535 pops, then reset asserted mid-response -> vga_rsp_valid=0 and served_count=0 with no clk edge, and memory data is retained.

Source files
------------

// File: rtl/vga_mem_responder.sv
// ---------------------------------------------------------------------------
// vga_mem_responder
//   256 x 32-bit word memory shared between a CPU port and a VGA read port.
//   The CPU port reads combinationally and writes on the clock edge; it is
//   never stalled. VGA read requests are accepted through a valid/ready
//   handshake. Each accepted request reads the memory on the accept edge and
//   pushes the word into a 2-entry response FIFO, so the response appears one
//   cycle after acceptance. Responses come back in request order, and every
//   consumed response increments served_count.
//
// Build option:
//   VGA_MEM_BYPASS_EN  defined   -> write-first: a same-edge CPU write and VGA
//                                   accept to the same word return cpu_wdata
//                      undefined -> read-first: the pre-write word is returned
//
// Ports:
//   clk            in   1   single clock, rising edge
//   reset          in   1   asynchronous active-high reset
//   cpu_we         in   1   CPU word write enable
//   cpu_addr       in  32   CPU byte address, bits [9:2] select the word
//   cpu_wdata      in  32   CPU write data
//   cpu_rdata      out 32   CPU combinational read data
//   vga_req_valid  in   1   VGA request present
//   vga_req_ready  out  1   responder can accept a request
//   vga_addr       in   8   VGA word address
//   vga_rsp_valid  out  1   vga_rdata holds a valid response
//   vga_rsp_ready  in   1   VGA consumes the response
//   vga_rdata      out 32   response data (FIFO head)
//   served_count   out 16   number of responses consumed, wraps
// ---------------------------------------------------------------------------
module vga_mem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        vga_req_valid,
  output logic        vga_req_ready,
  input  logic [7:0]  vga_addr,
  output logic        vga_rsp_valid,
  input  logic        vga_rsp_ready,
  output logic [31:0] vga_rdata,
  output logic [15:0] served_count
);

  logic [31:0] r_mem [0:255];
  logic [31:0] r_fifo [0:1];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [15:0] r_served;

  logic [7:0]  w_cpu_word;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_data;
  logic        w_unused_addr_bits;

  assign w_cpu_word         = cpu_addr[9:2];
  assign w_unused_addr_bits = ^{cpu_addr[31:10], cpu_addr[1:0]};

  assign cpu_rdata     = r_mem[w_cpu_word];
  assign vga_rsp_valid = (r_count != 2'd0);
  // A full FIFO can still take a request when its head leaves on the same edge.
  assign vga_req_ready = (r_count < 2'd2) || ((r_count == 2'd2) && vga_rsp_ready);
  assign w_push        = vga_req_valid && vga_req_ready;
  assign w_pop         = vga_rsp_valid && vga_rsp_ready;
  assign vga_rdata     = vga_rsp_valid ? r_fifo[r_rd_ptr] : 32'd0;
  assign served_count  = r_served;

  always_comb begin
    w_push_data = r_mem[vga_addr];
`ifdef VGA_MEM_BYPASS_EN
    if (cpu_we && (w_cpu_word == vga_addr)) begin
      w_push_data = cpu_wdata;
    end
`endif
  end

  // Memory contents survive reset; writes are only blocked while it is held.
  always_ff @(posedge clk) begin
    if (cpu_we && !reset) begin
      r_mem[w_cpu_word] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo[0] <= 32'd0;
      r_fifo[1] <= 32'd0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_served  <= 16'd0;
    end else begin
      // When full with push and pop together, wr_ptr equals rd_ptr: the slot
      // being vacated by the pop is the one refilled by the push.
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_served <= r_served + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mem_responder.sv
module tb_vga_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        vga_req_valid;
  logic        vga_req_ready;
  logic [7:0]  vga_addr;
  logic        vga_rsp_valid;
  logic        vga_rsp_ready;
  logic [31:0] vga_rdata;
  logic [15:0] served_count;

  int n_checks = 0;
  int n_errors = 0;

  vga_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .vga_req_valid (vga_req_valid),
    .vga_req_ready (vga_req_ready),
    .vga_addr      (vga_addr),
    .vga_rsp_valid (vga_rsp_valid),
    .vga_rsp_ready (vga_rsp_ready),
    .vga_rdata     (vga_rdata),
    .served_count  (served_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } cpu_vec_t;

  cpu_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    tick();
    cpu_we    = 1'b0;
  endtask

  logic [31:0] exp_same_edge;
  bit          reached;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[1] = '{1'b1, 32'h0000_0044, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'hA5A5_A5A5};
    vecs[3] = '{1'b1, 32'hFFFF_FC43, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678};
    vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,         32'h5A5A_5A5A};
    vecs[6] = '{1'b1, 32'h0000_03FC, 32'hFFFF_0000, 32'hFFFF_0000};
    vecs[7] = '{1'b0, 32'h0000_07FC, 32'h0,         32'hFFFF_0000};

    reset = 1'b1;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req_valid = 1'b0; vga_addr = '0; vga_rsp_ready = 1'b0;
`ifdef VGA_MEM_BYPASS_EN
    exp_same_edge = 32'h2;
`else
    exp_same_edge = 32'h1;
`endif

    #2;
    check("rst_rsp_valid", {31'd0, vga_rsp_valid}, 32'd0);
    check("rst_served", {16'd0, served_count}, 32'd0);
    check("rst_rdata", vga_rdata, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, vga_req_ready}, 32'd1);

    // Basic read path: 1-cycle latency and pop on rsp_ready.
    cpu_write(32'h14, 32'hDEAD_BEEF);
    check("cpu_rd_0x14", cpu_rdata, 32'hDEAD_BEEF);
    vga_req_valid = 1'b1; vga_addr = 8'd5; vga_rsp_ready = 1'b1;
    #1;
    check("basic_pre_valid", {31'd0, vga_rsp_valid}, 32'd0);
    tick();
    vga_req_valid = 1'b0;
    check("basic_valid", {31'd0, vga_rsp_valid}, 32'd1);
    check("basic_rdata", vga_rdata, 32'hDEAD_BEEF);
    tick();
    check("basic_served", {16'd0, served_count}, 32'd1);
    check("basic_empty", {31'd0, vga_rsp_valid}, 32'd0);

    // CPU port table.
    for (int i = 0; i < 8; i++) begin
      cpu_addr = vecs[i].addr;
      if (vecs[i].we) cpu_write(vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("cpu_vec%0d", i), cpu_rdata, vecs[i].exp);
    end

    // Same-edge CPU write and VGA accept on word 7.
    cpu_write(32'h1C, 32'h1);
    cpu_we = 1'b1; cpu_addr = 32'h1C; cpu_wdata = 32'h2;
    vga_req_valid = 1'b1; vga_addr = 8'd7; vga_rsp_ready = 1'b0;
    tick();
    cpu_we = 1'b0; vga_req_valid = 1'b0;
    check("same_edge_rdata", vga_rdata, exp_same_edge);
    check("same_edge_cpu", cpu_rdata, 32'h2);
    vga_rsp_ready = 1'b1;
    tick();
    vga_req_valid = 1'b1; vga_addr = 8'd7;
    tick();
    vga_req_valid = 1'b0;
    check("word7_later", vga_rdata, 32'h2);
    tick();
    check("served_after_w7", {16'd0, served_count}, 32'd3);

    // Backpressure: two accepted, third refused until the head drains.
    cpu_write(32'h4, 32'h11);
    cpu_write(32'h8, 32'h22);
    cpu_write(32'hC, 32'h33);
    vga_rsp_ready = 1'b0;
    vga_req_valid = 1'b1; vga_addr = 8'd1;
    #1;
    check("bp_ready1", {31'd0, vga_req_ready}, 32'd1);
    tick();
    vga_addr = 8'd2;
    check("bp_ready2", {31'd0, vga_req_ready}, 32'd1);
    tick();
    vga_addr = 8'd3;
    #1;
    check("bp_ready3", {31'd0, vga_req_ready}, 32'd0);
    check("bp_head", vga_rdata, 32'h11);
    tick();
    check("bp_hold", vga_rdata, 32'h11);
    check("bp_still_full", {31'd0, vga_req_ready}, 32'd0);
    vga_rsp_ready = 1'b1;
    #1;
    check("bp_ready_on_pop", {31'd0, vga_req_ready}, 32'd1);
    tick();
    vga_req_valid = 1'b0;
    check("bp_rsp2", vga_rdata, 32'h22);
    tick();
    check("bp_rsp3", vga_rdata, 32'h33);
    tick();
    check("bp_drained", {31'd0, vga_rsp_valid}, 32'd0);
    check("bp_served", {16'd0, served_count}, 32'd6);

    // Full FIFO with simultaneous pop and push.
    vga_rsp_ready = 1'b0;
    vga_req_valid = 1'b1; vga_addr = 8'd16;
    tick();
    vga_addr = 8'd17;
    tick();
    vga_addr = 8'd5; vga_rsp_ready = 1'b1;
    #1;
    check("full_ready", {31'd0, vga_req_ready}, 32'd1);
    tick();
    vga_req_valid = 1'b0; vga_rsp_ready = 1'b0;
    #1;
    check("full_served", {16'd0, served_count}, 32'd7);
    check("full_head", vga_rdata, 32'h5A5A_5A5A);
    check("full_count2", {31'd0, vga_req_ready}, 32'd0);
    vga_rsp_ready = 1'b1;
    tick();
    check("full_next", vga_rdata, 32'hDEAD_BEEF);
    tick();
    check("full_drained", {31'd0, vga_rsp_valid}, 32'd0);
    check("full_served2", {16'd0, served_count}, 32'd9);

    // Stream until served_count reaches 0xFFFF, then reset mid-response.
    vga_req_valid = 1'b1; vga_addr = 8'd5; vga_rsp_ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 70000 && !reached; c++) begin
      tick();
      if (served_count == 16'hFFFF) reached = 1'b1;
    end
    vga_req_valid = 1'b0; vga_rsp_ready = 1'b0;
    check("stream_reached", {31'd0, reached}, 32'd1);
    check("stream_served", {16'd0, served_count}, 32'h0000_FFFF);
    check("stream_pending", {31'd0, vga_rsp_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, vga_rsp_valid}, 32'd0);
    check("midrst_served", {16'd0, served_count}, 32'd0);
    check("midrst_rdata", vga_rdata, 32'd0);
    cpu_addr = 32'h14;
    #1;
    check("midrst_mem", cpu_rdata, 32'hDEAD_BEEF);
    cpu_we = 1'b1; cpu_wdata = 32'h0;
    tick();
    cpu_we = 1'b0;
    check("rst_we_ignored", cpu_rdata, 32'hDEAD_BEEF);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_valid", {31'd0, vga_rsp_valid}, 32'd0);
    check("post_rst_served", {16'd0, served_count}, 32'd0);
    check("post_rst_ready", {31'd0, vga_req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
